simd_dot_accumulator: RTL and testbench
=======================================

Name: simd_dot_accumulator

Overview:
- Downstream stage of the dp32 SIMD dot-product multiplier.
- Each cycle it consumes one beat of dp32 results: mul_int32, sum_int16, sum_int8, sum_int4 and sum_int2.
- It selects the lane matching the precision mode and accumulates it, unsigned, over a vector of beats delimited by in_last.
- It presents the final dot product to the consumer through a valid/ready handshake.

Parameters:
- ACC_W, 80, accumulator and out_acc width in bits; must be >= 64.
- MAX_LEN, 1024, maximum beats per vector; forces termination when reached.
- CNT_W, 11, beat-counter width; must satisfy 2^CNT_W > MAX_LEN.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  beat present.
- in_ready  out  1  block can accept a beat.
- in_last  in  1  beat is the final beat of the vector.
- mode  in  3  precision: 0=INT2, 1=INT4, 2=INT8, 3=INT16, 4=INT32; 5-7 reserved.
- sum_int2  in  8  INT2 lane partial sum.
- sum_int4  in  11  INT4 lane partial sum.
- sum_int8  in  18  INT8 lane partial sum.
- sum_int16  in  33  INT16 lane partial sum.
- mul_int32  in  64  INT32 product.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_acc  out  ACC_W  accumulated dot product.
- out_count  out  CNT_W  beats accumulated in this vector.
- out_mode  out  3  mode latched on the first beat.
- out_ovf  out  1  accumulator saturated during this vector.
- out_trunc  out  1  vector terminated by MAX_LEN rather than in_last.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; acc, count, out_acc, out_count, out_mode, out_ovf, out_trunc, out_valid all 0; in_ready=1 on the following cycle.
  - rst overrides everything, including mid-vector and while out_valid is high; the partial vector is discarded.
- A beat is accepted when in_valid && in_ready at a clk edge.
- Lane select: the lane is chosen by the latched mode. On the first beat of a vector, mode itself is used.
  - Selected lane is zero-extended to ACC_W.
  - Reserved mode (5-7) contributes 0; the beat is still counted.
- FSM:
  - IDLE: in_ready=1, out_valid=0. On an accepted beat:
    - acc=lane, count=1, mode latched, ovf=0.
    - Go to DONE if the beat is terminal (see MAX_LEN), otherwise go to ACC.
  - ACC: in_ready=1.
    - Accepted beat: acc=sat(acc+lane), count+1.
    - mode input is ignored for the rest of the vector.
    - Go to DONE if the beat is terminal.
  - DONE: in_ready=0, out_valid=1; out_* are registered and stable.
    - out_ready=1 at an edge returns to IDLE, with out_valid=0 the next cycle.
    - Otherwise hold indefinitely; in_* are ignored.
- Terminal beat: in_last=1, or the count after this beat == MAX_LEN. out_trunc=1 only if the count reached MAX_LEN with in_last=0.
- Latency: out_valid rises the cycle after the terminal beat is accepted.
  - Throughput is one vector per (N+1) cycles when out_ready is held at 1.
  - No bubble-free back-to-back: in_ready=0 in the DONE cycle.
- Saturation: if acc+lane overflows ACC_W bits, acc = all ones and ovf sticks at 1 until the next vector's first beat.
- in_valid=0 in ACC: state and acc hold; gaps of any length are allowed.
- A single-beat vector (in_last on the first beat) yields out_count=1 and out_acc=lane.
- All arithmetic is unsigned. No combinational path from in_* to out_*.
- in_ready is a function of state only.

Test Plan:
- Reset then INT8 (mode=2): three beats with sum_int8=100, 200, 300, in_last on the third, out_ready=1 -> out_valid one cycle after the third beat; out_acc=600, out_count=3, out_mode=2, out_ovf=0, out_trunc=0.
- INT32 (mode=4): mul_int32=64'hFFFF_FFFF_FFFF_FFFF for 2 beats, ACC_W=80 -> out_acc=0x1_FFFF_FFFF_FFFF_FFFE.
- Saturation with ACC_W=64, mode=4: beats of 2^63 and 2^63 -> out_acc=64'hFFFF_FFFF_FFFF_FFFF, out_ovf=1.
  - The next vector (mode=0, one beat with sum_int2=5) -> out_acc=5, out_ovf=0.
- Backpressure and mode latch:
  - out_ready=0 for 5 cycles after out_valid -> out_valid stays high, out_acc stable, in_ready=0; in_valid pulses are ignored and do not alter the result.
  - A mode change from 1 to 3 mid-vector is ignored: sum_int4 keeps being used.
- MAX_LEN=4, mode=1, sum_int4=10 every beat, in_last never asserted -> done after 4 beats; out_acc=40, out_count=4, out_trunc=1.
- Reset mid-vector after 2 beats, then a single beat with sum_int16=7 and in_last=1 in mode=3 -> out_acc=7, out_count=1.

Source files
------------

// File: rtl/simd_dot_accumulator.sv
// simd_dot_accumulator
// Accumulates the precision-selected lane of the dp32 dot-product
// multiplier over a vector of beats delimited by in_last (or by MAX_LEN),
// then hands the result to the consumer over a valid/ready handshake.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for the first beat of a vector
// S_ACC  | vector in progress, accumulating beats
// S_DONE | result held on out_*, waiting for out_ready
module simd_dot_accumulator #(
  parameter int ACC_W   = 80,
  parameter int MAX_LEN = 1024,
  parameter int CNT_W   = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [2:0]       mode,
  input  logic [7:0]       sum_int2,
  input  logic [10:0]      sum_int4,
  input  logic [17:0]      sum_int8,
  input  logic [32:0]      sum_int16,
  input  logic [63:0]      mul_int32,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic [2:0]       out_mode,
  output logic             out_ovf,
  output logic             out_trunc
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);

  state_t           state;
  state_t           state_next;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;
  logic [ACC_W-1:0] lane;
  logic [ACC_W:0]   sum_wide;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic [2:0]       mode_q;
  logic [2:0]       mode_sel;
  logic             ovf;
  logic             ovf_next;
  logic             accept;
  logic             hit_max;
  logic             terminal;

  // in_ready is high in IDLE and ACC, so acceptance only depends on state.
  assign accept   = in_valid && (state != S_DONE);
  // The first beat uses the live mode; later beats use the latched one.
  assign mode_sel = (state == S_IDLE) ? mode : mode_q;

  // Pick the lane for the active precision, zero-extended; reserved modes add 0.
  always_comb begin
    lane = '0;
    case (mode_sel)
      3'd0:    lane = ACC_W'(sum_int2);
      3'd1:    lane = ACC_W'(sum_int4);
      3'd2:    lane = ACC_W'(sum_int8);
      3'd3:    lane = ACC_W'(sum_int16);
      3'd4:    lane = ACC_W'(mul_int32);
      default: lane = '0;
    endcase
  end

  // Next accumulator/count/overflow for an accepted beat, with saturation.
  always_comb begin
    sum_wide   = {1'b0, acc} + {1'b0, lane};
    acc_next   = acc;
    count_next = count;
    ovf_next   = ovf;
    if (state == S_IDLE) begin
      acc_next   = lane;
      count_next = CNT_W'(1);
      ovf_next   = 1'b0;
    end else begin
      count_next = count + CNT_W'(1);
      if (sum_wide[ACC_W]) begin
        acc_next = '1;
        ovf_next = 1'b1;
      end else begin
        acc_next = sum_wide[ACC_W-1:0];
      end
    end
    hit_max  = (count_next == MAX_CNT);
    terminal = in_last || hit_max;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs, decoded from state alone.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = terminal ? S_DONE : S_ACC;
        end
      end
      S_ACC: begin
        in_ready = 1'b1;
        if (in_valid && terminal) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Working accumulator, beat count, latched mode and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      count  <= '0;
      mode_q <= '0;
      ovf    <= 1'b0;
    end else if (accept) begin
      acc   <= acc_next;
      count <= count_next;
      ovf   <= ovf_next;
      if (state == S_IDLE) begin
        mode_q <= mode;
      end
    end
  end

  // Result registers, captured on the terminal beat and held through DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_acc   <= '0;
      out_count <= '0;
      out_mode  <= '0;
      out_ovf   <= 1'b0;
      out_trunc <= 1'b0;
    end else if (accept && terminal) begin
      out_acc   <= acc_next;
      out_count <= count_next;
      out_mode  <= mode_sel;
      out_ovf   <= ovf_next;
      out_trunc <= hit_max && !in_last;
    end
  end

endmodule

// File: tb/tb_simd_dot_accumulator.sv
// Bench for simd_dot_accumulator: three instances (default, ACC_W=64,
// MAX_LEN=4) share one stimulus stream; each is checked every cycle against
// a per-instance vector-level reference model, plus directed result checks.
module tb_simd_dot_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_last;
  logic [2:0]  mode;
  logic [7:0]  sum_int2;
  logic [10:0] sum_int4;
  logic [17:0] sum_int8;
  logic [32:0] sum_int16;
  logic [63:0] mul_int32;
  logic        out_ready;

  logic        rdy0, rdy1, rdy2;
  logic        vld0, vld1, vld2;
  logic [79:0] acc0;
  logic [63:0] acc1;
  logic [79:0] acc2;
  logic [10:0] cnt0, cnt1;
  logic [2:0]  cnt2;
  logic [2:0]  md0, md1, md2;
  logic        ovf0, ovf1, ovf2;
  logic        trc0, trc1, trc2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  simd_dot_accumulator #(.ACC_W(80), .MAX_LEN(1024), .CNT_W(11)) d0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_last(in_last),
    .mode(mode), .sum_int2(sum_int2), .sum_int4(sum_int4), .sum_int8(sum_int8),
    .sum_int16(sum_int16), .mul_int32(mul_int32), .out_valid(vld0), .out_ready(out_ready),
    .out_acc(acc0), .out_count(cnt0), .out_mode(md0), .out_ovf(ovf0), .out_trunc(trc0));

  simd_dot_accumulator #(.ACC_W(64), .MAX_LEN(1024), .CNT_W(11)) d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_last(in_last),
    .mode(mode), .sum_int2(sum_int2), .sum_int4(sum_int4), .sum_int8(sum_int8),
    .sum_int16(sum_int16), .mul_int32(mul_int32), .out_valid(vld1), .out_ready(out_ready),
    .out_acc(acc1), .out_count(cnt1), .out_mode(md1), .out_ovf(ovf1), .out_trunc(trc1));

  simd_dot_accumulator #(.ACC_W(80), .MAX_LEN(4), .CNT_W(3)) d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .in_last(in_last),
    .mode(mode), .sum_int2(sum_int2), .sum_int4(sum_int4), .sum_int8(sum_int8),
    .sum_int16(sum_int16), .mul_int32(mul_int32), .out_valid(vld2), .out_ready(out_ready),
    .out_acc(acc2), .out_count(cnt2), .out_mode(md2), .out_ovf(ovf2), .out_trunc(trc2));

  logic [127:0] o_acc [3];
  logic [15:0]  o_cnt [3];
  logic [2:0]   o_md  [3];
  logic         o_rdy [3];
  logic         o_vld [3];
  logic         o_ovf [3];
  logic         o_trc [3];

  assign o_acc[0] = 128'(acc0);
  assign o_acc[1] = 128'(acc1);
  assign o_acc[2] = 128'(acc2);
  assign o_cnt[0] = 16'(cnt0);
  assign o_cnt[1] = 16'(cnt1);
  assign o_cnt[2] = 16'(cnt2);
  assign o_md[0]  = md0;
  assign o_md[1]  = md1;
  assign o_md[2]  = md2;
  assign o_rdy[0] = rdy0;
  assign o_rdy[1] = rdy1;
  assign o_rdy[2] = rdy2;
  assign o_vld[0] = vld0;
  assign o_vld[1] = vld1;
  assign o_vld[2] = vld2;
  assign o_ovf[0] = ovf0;
  assign o_ovf[1] = ovf1;
  assign o_ovf[2] = ovf2;
  assign o_trc[0] = trc0;
  assign o_trc[1] = trc1;
  assign o_trc[2] = trc2;

  // Reference model: one vector at a time, plain arithmetic on wide integers.
  bit           collecting [3];
  bit           holding    [3];
  logic [127:0] m_acc      [3];
  int           m_cnt      [3];
  logic [2:0]   m_mode     [3];
  bit           m_ovf      [3];
  logic [127:0] r_acc      [3];
  int           r_cnt      [3];
  logic [2:0]   r_mode     [3];
  bit           r_ovf      [3];
  bit           r_trunc    [3];

  function automatic int acc_w(input int k);
    return (k == 1) ? 64 : 80;
  endfunction

  function automatic int max_len(input int k);
    return (k == 2) ? 4 : 1024;
  endfunction

  function automatic logic [127:0] lane_of(input logic [2:0] m);
    case (m)
      3'd0:    return 128'(sum_int2);
      3'd1:    return 128'(sum_int4);
      3'd2:    return 128'(sum_int8);
      3'd3:    return 128'(sum_int16);
      3'd4:    return 128'(mul_int32);
      default: return 128'd0;
    endcase
  endfunction

  task automatic model_step();
    logic [127:0] s;
    logic [127:0] lim;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        collecting[k] = 0; holding[k] = 0;
        m_acc[k] = 0; m_cnt[k] = 0; m_mode[k] = 0; m_ovf[k] = 0;
        r_acc[k] = 0; r_cnt[k] = 0; r_mode[k] = 0; r_ovf[k] = 0; r_trunc[k] = 0;
      end else if (holding[k]) begin
        if (out_ready) holding[k] = 0;
      end else if (in_valid) begin
        if (!collecting[k]) begin
          m_mode[k] = mode;
          m_acc[k]  = lane_of(mode);
          m_cnt[k]  = 1;
          m_ovf[k]  = 0;
          collecting[k] = 1;
        end else begin
          lim = (128'd1 << acc_w(k)) - 128'd1;
          s   = m_acc[k] + lane_of(m_mode[k]);
          if (s > lim) begin
            m_acc[k] = lim;
            m_ovf[k] = 1;
          end else begin
            m_acc[k] = s;
          end
          m_cnt[k]++;
        end
        if (in_last || m_cnt[k] == max_len(k)) begin
          collecting[k] = 0;
          holding[k]    = 1;
          r_acc[k]   = m_acc[k];
          r_cnt[k]   = m_cnt[k];
          r_mode[k]  = m_mode[k];
          r_ovf[k]   = m_ovf[k];
          r_trunc[k] = !in_last && (m_cnt[k] == max_len(k));
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input int k);
    chk($sformatf("d%0d_in_ready", k), 128'(o_rdy[k]), 128'(!holding[k]));
    chk($sformatf("d%0d_out_valid", k), 128'(o_vld[k]), 128'(holding[k]));
    if (holding[k]) begin
      chk($sformatf("d%0d_out_acc", k), o_acc[k], r_acc[k]);
      chk($sformatf("d%0d_out_count", k), 128'(o_cnt[k]), 128'(r_cnt[k]));
      chk($sformatf("d%0d_out_mode", k), 128'(o_md[k]), 128'(r_mode[k]));
      chk($sformatf("d%0d_out_ovf", k), 128'(o_ovf[k]), 128'(r_ovf[k]));
      chk($sformatf("d%0d_out_trunc", k), 128'(o_trc[k]), 128'(r_trunc[k]));
    end
  endtask

  // One clock: update model with the inputs present at the edge, then compare.
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) check_model(k);
  endtask

  task automatic random_lanes();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    sum_int2  = r[7:0];
    sum_int4  = r[18:8];
    sum_int8  = r[36:19];
    r = {$urandom(), $urandom()};
    sum_int16 = r[32:0];
    mul_int32 = {$urandom(), $urandom()};
  endtask

  // Present one beat: mode input md, value val placed on lane lane_md.
  task automatic beat(input logic [2:0] md, input logic [2:0] lane_md,
                      input logic [63:0] val, input bit last);
    random_lanes();
    case (lane_md)
      3'd0: sum_int2  = val[7:0];
      3'd1: sum_int4  = val[10:0];
      3'd2: sum_int8  = val[17:0];
      3'd3: sum_int16 = val[32:0];
      3'd4: mul_int32 = val;
      default: ;
    endcase
    mode     = md;
    in_valid = 1'b1;
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; mode = 3'd0; out_ready = 1'b1;
    random_lanes();
    idle(2);
    rst = 1'b0;
    idle(1);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_d%0d_acc", k), o_acc[k], 128'd0);
      chk($sformatf("rst_d%0d_count", k), 128'(o_cnt[k]), 128'd0);
      chk($sformatf("rst_d%0d_flags", k),
          128'({o_vld[k], o_ovf[k], o_trc[k], o_md[k]}), 128'd0);
      chk($sformatf("rst_d%0d_in_ready", k), 128'(o_rdy[k]), 128'd1);
    end

    // INT8: 100 + 200 + 300
    beat(3'd2, 3'd2, 64'd100, 1'b0);
    beat(3'd2, 3'd2, 64'd200, 1'b0);
    beat(3'd2, 3'd2, 64'd300, 1'b1);
    chk("int8_valid", 128'(vld0), 128'd1);
    chk("int8_acc", o_acc[0], 128'd600);
    chk("int8_count", 128'(cnt0), 128'd3);
    chk("int8_mode", 128'(md0), 128'd2);
    chk("int8_ovf_trunc", 128'({ovf0, trc0}), 128'd0);
    idle(1);
    chk("int8_release", 128'(vld0), 128'd0);

    // INT32: two all-ones products
    beat(3'd4, 3'd4, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    beat(3'd4, 3'd4, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    chk("int32_acc80", o_acc[0], 128'h1_FFFF_FFFF_FFFF_FFFE);
    chk("int32_ovf80", 128'(ovf0), 128'd0);
    idle(1);

    // Saturation on the 64-bit instance, then cleared by the next vector
    beat(3'd4, 3'd4, 64'h8000_0000_0000_0000, 1'b0);
    beat(3'd4, 3'd4, 64'h8000_0000_0000_0000, 1'b1);
    chk("sat_acc64", o_acc[1], 128'hFFFF_FFFF_FFFF_FFFF);
    chk("sat_ovf64", 128'(ovf1), 128'd1);
    idle(1);
    beat(3'd0, 3'd0, 64'd5, 1'b1);
    chk("post_sat_acc64", o_acc[1], 128'd5);
    chk("post_sat_ovf64", 128'(ovf1), 128'd0);
    idle(1);

    // Backpressure with a mid-vector mode change that must be ignored
    out_ready = 1'b0;
    beat(3'd1, 3'd1, 64'd3, 1'b0);
    beat(3'd3, 3'd1, 64'd4, 1'b0);
    beat(3'd3, 3'd1, 64'd5, 1'b1);
    chk("bp_acc", o_acc[0], 128'd12);
    chk("bp_mode", 128'(md0), 128'd1);
    for (int i = 0; i < 5; i++) begin
      random_lanes();
      mode     = 3'($urandom_range(0, 7));
      in_valid = 1'($urandom_range(0, 1));
      in_last  = 1'($urandom_range(0, 1));
      step();
      chk("bp_hold_valid", 128'(vld0), 128'd1);
      chk("bp_hold_ready", 128'(rdy0), 128'd0);
      chk("bp_hold_acc", o_acc[0], 128'd12);
    end
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    idle(1);
    chk("bp_release", 128'(vld0), 128'd0);

    // MAX_LEN=4 instance terminates without in_last
    for (int i = 0; i < 4; i++) beat(3'd1, 3'd1, 64'd10, 1'b0);
    chk("trunc_valid", 128'(vld2), 128'd1);
    chk("trunc_acc", o_acc[2], 128'd40);
    chk("trunc_count", 128'(cnt2), 128'd4);
    chk("trunc_flag", 128'(trc2), 128'd1);
    chk("trunc_long_busy", 128'(vld0), 128'd0);
    beat(3'd1, 3'd1, 64'd10, 1'b1);
    chk("long_acc", o_acc[0], 128'd50);
    chk("long_trunc", 128'(trc0), 128'd0);
    idle(1);

    // Reset mid-vector discards the partial sum
    beat(3'd2, 3'd2, 64'd77, 1'b0);
    beat(3'd2, 3'd2, 64'd88, 1'b0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    beat(3'd3, 3'd3, 64'd7, 1'b1);
    chk("rst_mid_acc", o_acc[0], 128'd7);
    chk("rst_mid_count", 128'(cnt0), 128'd1);
    chk("rst_mid_mode", 128'(md0), 128'd3);
    idle(1);

    // Randomized traffic checked against the model
    for (int i = 0; i < 600; i++) begin
      random_lanes();
      rst       = ($urandom_range(0, 99) == 0);
      mode      = 3'($urandom_range(0, 7));
      in_valid  = ($urandom_range(0, 9) < 7);
      in_last   = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 9) < 6);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
